// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader and the instruction-fetch stage.
package uart_program_loader_pkg;

  // Word-address width of the program ROM upload port.
  localparam int UPG_ADDR_W = 14;

  // Loader FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } state_e;

endpackage

// File: rtl/uart_program_loader_byte_timeout_counter.sv
// Inter-byte idle counter: counts enabled cycles without a received byte and
// flags the cycle in which the count would reach TIMEOUT_CYCLES.
module byte_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  input  logic clear_i,
  output logic tc_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_q;

  // Clear on any byte or while disabled; otherwise count idle cycles.
  always_ff @(posedge clock) begin
    if (reset || clear_i || !en_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // A byte arriving in the terminal cycle takes priority and suppresses the flag.
  assign tc_o = en_i && !clear_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_program_loader.sv
// Parses a 2-byte little-endian word count, assembles little-endian 32-bit
// words from the UART byte stream and writes them to the program ROM.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int ADDR_W         = UPG_ADDR_W,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              busy_o,
  output logic              err_o
);

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       word_q, word_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic [15:0]       len_full;
  logic              timeout_tc;

  assign busy_o     = (state_q == LEN_HI) || (state_q == DATA);
  assign err_o      = (state_q == ERROR);
  assign upg_done_o = (state_q == DONE);
  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign len_full   = {rx_byte, len_lo_q};

  byte_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .en_i   (busy_o),
    .clear_i(rx_valid),
    .tc_o   (timeout_tc)
  );

  // State and datapath registers; reset also drops any pending write pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      len_lo_q   <= '0;
      n_q        <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      wen_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      wen_q      <= wen_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
    end
  end

  // Header parse, byte-lane assembly, write issue and timeout abort.
  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    wen_d      = 1'b0;
    adr_d      = adr_q;
    dat_d      = dat_q;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          len_lo_d = rx_byte;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (rx_valid) begin
          // Count bits above the address width are dropped.
          n_d        = len_full[ADDR_W-1:0];
          word_idx_d = '0;
          byte_idx_d = '0;
          state_d    = (len_full[ADDR_W-1:0] == '0) ? DONE : DATA;
        end else if (timeout_tc) begin
          state_d = ERROR;
        end
      end
      DATA: begin
        if (rx_valid) begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = rx_byte;
            2'd1: word_d[15:8]  = rx_byte;
            2'd2: word_d[23:16] = rx_byte;
            default: begin
              wen_d      = 1'b1;
              adr_d      = word_idx_q;
              dat_d      = {rx_byte, word_q};
              word_idx_d = word_idx_q + ADDR_W'(1);
              if ((word_idx_q + ADDR_W'(1)) == n_q) begin
                state_d = DONE;
              end
            end
          endcase
        end else if (timeout_tc) begin
          // Partial word is simply abandoned; nothing is written.
          state_d = ERROR;
        end
      end
      default: begin
        // DONE and ERROR are terminal until reset; bytes are ignored.
      end
    endcase
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader with a short timeout build.
module tb_uart_program_loader;

  localparam int AW = 14;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_valid = 1'b0;
  logic          upg_wen_o;
  logic [AW-1:0] upg_adr_o;
  logic [31:0]   upg_dat_o;
  logic          upg_done_o;
  logic          busy_o;
  logic          err_o;

  int checks = 0;
  int fails  = 0;
  int wen_total = 0;
  int base;

  uart_program_loader #(
    .ADDR_W(AW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .upg_wen_o (upg_wen_o),
    .upg_adr_o (upg_adr_o),
    .upg_dat_o (upg_dat_o),
    .upg_done_o(upg_done_o),
    .busy_o    (busy_o),
    .err_o     (err_o)
  );

  always #5 clock = ~clock;

  // Count write pulses away from the active edge.
  always @(negedge clock) begin
    if (upg_wen_o === 1'b1) wen_total <= wen_total + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (upg_wen_o !== 1'b0) begin fails++; $display("FAIL reset_wen got=%b want=0", upg_wen_o); end
    checks++; if (upg_adr_o !== '0) begin fails++; $display("FAIL reset_adr got=%h want=0", upg_adr_o); end
    checks++; if (upg_dat_o !== 32'h0) begin fails++; $display("FAIL reset_dat got=%h want=0", upg_dat_o); end
    checks++; if (upg_done_o !== 1'b0) begin fails++; $display("FAIL reset_done got=%b want=0", upg_done_o); end
    checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy_o); end
    checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err got=%b want=0", err_o); end
    $display("test_reset: outputs checked after reset");
  endtask

  task automatic test_two_word;
    do_reset();
    base = wen_total;
    send_byte(8'h02); send_byte(8'h00);
    checks++; if (busy_o !== 1'b1) begin fails++; $display("FAIL two_busy got=%b want=1", busy_o); end
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    checks++; if (upg_wen_o !== 1'b1) begin fails++; $display("FAIL two_w0_wen got=%b want=1", upg_wen_o); end
    checks++; if (upg_adr_o !== 14'd0) begin fails++; $display("FAIL two_w0_adr got=%h want=0", upg_adr_o); end
    checks++; if (upg_dat_o !== 32'h44332211) begin fails++; $display("FAIL two_w0_dat got=%h want=44332211", upg_dat_o); end
    checks++; if (upg_done_o !== 1'b0) begin fails++; $display("FAIL two_w0_done got=%b want=0", upg_done_o); end
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    checks++; if (upg_wen_o !== 1'b1) begin fails++; $display("FAIL two_w1_wen got=%b want=1", upg_wen_o); end
    checks++; if (upg_adr_o !== 14'd1) begin fails++; $display("FAIL two_w1_adr got=%h want=1", upg_adr_o); end
    checks++; if (upg_dat_o !== 32'hDDCCBBAA) begin fails++; $display("FAIL two_w1_dat got=%h want=ddccbbaa", upg_dat_o); end
    checks++; if (upg_done_o !== 1'b1) begin fails++; $display("FAIL two_w1_done got=%b want=1", upg_done_o); end
    tick(1);
    checks++; if (upg_wen_o !== 1'b0) begin fails++; $display("FAIL two_wen_pulse_width got=%b want=0", upg_wen_o); end
    tick(3);
    checks++; if (wen_total - base !== 2) begin fails++; $display("FAIL two_wen_count got=%0d want=2", wen_total - base); end
    checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL two_busy_end got=%b want=0", busy_o); end
    $display("test_two_word: 2-word load, writes=%0d", wen_total - base);
  endtask

  task automatic test_zero_len;
    do_reset();
    base = wen_total;
    send_byte(8'h00); send_byte(8'h00);
    checks++; if (upg_done_o !== 1'b1) begin fails++; $display("FAIL zero_done got=%b want=1", upg_done_o); end
    checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL zero_busy got=%b want=0", busy_o); end
    tick(2);
    checks++; if (wen_total - base !== 0) begin fails++; $display("FAIL zero_wen_count got=%0d want=0", wen_total - base); end
    $display("test_zero_len: zero-length load, done=%b", upg_done_o);
  endtask

  task automatic test_timeout;
    do_reset();
    base = wen_total;
    send_byte(8'h01); send_byte(8'h00);
    // A byte landing in the terminal-count cycle must win.
    tick(15);
    send_byte(8'h11);
    checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL to_tie_err got=%b want=0", err_o); end
    checks++; if (busy_o !== 1'b1) begin fails++; $display("FAIL to_tie_busy got=%b want=1", busy_o); end
    send_byte(8'h22);
    tick(15);
    checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL to_early_err got=%b want=0", err_o); end
    tick(1);
    checks++; if (err_o !== 1'b1) begin fails++; $display("FAIL to_err got=%b want=1", err_o); end
    checks++; if (upg_done_o !== 1'b0) begin fails++; $display("FAIL to_done got=%b want=0", upg_done_o); end
    checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL to_busy got=%b want=0", busy_o); end
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    tick(2);
    checks++; if (err_o !== 1'b1) begin fails++; $display("FAIL to_sticky_err got=%b want=1", err_o); end
    checks++; if (upg_done_o !== 1'b0) begin fails++; $display("FAIL to_late_done got=%b want=0", upg_done_o); end
    checks++; if (wen_total - base !== 0) begin fails++; $display("FAIL to_wen_count got=%0d want=0", wen_total - base); end
    checks++; if (upg_dat_o !== 32'h0) begin fails++; $display("FAIL to_dat got=%h want=0", upg_dat_o); end
    $display("test_timeout: mid-word timeout, err=%b", err_o);
  endtask

  task automatic test_back_to_back;
    do_reset();
    base = wen_total;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    checks++; if (upg_wen_o !== 1'b1) begin fails++; $display("FAIL b2b_wen got=%b want=1", upg_wen_o); end
    checks++; if (upg_dat_o !== 32'hD4C3B2A1) begin fails++; $display("FAIL b2b_dat got=%h want=d4c3b2a1", upg_dat_o); end
    checks++; if (upg_done_o !== 1'b1) begin fails++; $display("FAIL b2b_done got=%b want=1", upg_done_o); end
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    tick(2);
    checks++; if (wen_total - base !== 1) begin fails++; $display("FAIL b2b_wen_count got=%0d want=1", wen_total - base); end
    checks++; if (upg_done_o !== 1'b1) begin fails++; $display("FAIL b2b_done_hold got=%b want=1", upg_done_o); end
    checks++; if (upg_adr_o !== 14'd0) begin fails++; $display("FAIL b2b_adr_hold got=%h want=0", upg_adr_o); end
    checks++; if (upg_dat_o !== 32'hD4C3B2A1) begin fails++; $display("FAIL b2b_dat_hold got=%h want=d4c3b2a1", upg_dat_o); end
    $display("test_back_to_back: 1-word load plus trailing bytes, writes=%0d", wen_total - base);
  endtask

  task automatic test_reset_mid;
    do_reset();
    send_byte(8'h03); send_byte(8'h00);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i));
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++; if (upg_wen_o !== 1'b0) begin fails++; $display("FAIL rmid_wen got=%b want=0", upg_wen_o); end
    checks++; if (upg_dat_o !== 32'h0) begin fails++; $display("FAIL rmid_dat got=%h want=0", upg_dat_o); end
    checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rmid_busy got=%b want=0", busy_o); end
    checks++; if (upg_done_o !== 1'b0) begin fails++; $display("FAIL rmid_done got=%b want=0", upg_done_o); end
    base = wen_total;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    checks++; if (upg_wen_o !== 1'b1) begin fails++; $display("FAIL rmid_new_wen got=%b want=1", upg_wen_o); end
    checks++; if (upg_adr_o !== 14'd0) begin fails++; $display("FAIL rmid_new_adr got=%h want=0", upg_adr_o); end
    checks++; if (upg_dat_o !== 32'hDEADBEEF) begin fails++; $display("FAIL rmid_new_dat got=%h want=deadbeef", upg_dat_o); end
    checks++; if (upg_done_o !== 1'b1) begin fails++; $display("FAIL rmid_new_done got=%b want=1", upg_done_o); end
    // Reset coinciding with the last byte of a word suppresses its write.
    do_reset();
    base = wen_total;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    rx_byte = 8'h04; rx_valid = 1'b1; reset = 1'b1;
    tick(1);
    rx_valid = 1'b0; reset = 1'b0;
    tick(2);
    checks++; if (wen_total - base !== 0) begin fails++; $display("FAIL rsup_wen_count got=%0d want=0", wen_total - base); end
    checks++; if (upg_done_o !== 1'b0) begin fails++; $display("FAIL rsup_done got=%b want=0", upg_done_o); end
    $display("test_reset_mid: reset mid-transfer then fresh load");
  endtask

  task automatic test_header_trunc;
    logic [31:0] exp_word;
    do_reset();
    base = wen_total;
    send_byte(8'h05); send_byte(8'h80);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 4; j++) send_byte(8'(k * 4 + j));
      exp_word = {8'(k * 4 + 3), 8'(k * 4 + 2), 8'(k * 4 + 1), 8'(k * 4)};
      checks++; if (upg_wen_o !== 1'b1) begin fails++; $display("FAIL trunc_wen k=%0d got=%b want=1", k, upg_wen_o); end
      checks++; if (upg_adr_o !== 14'(k)) begin fails++; $display("FAIL trunc_adr got=%h want=%h", upg_adr_o, 14'(k)); end
      checks++; if (upg_dat_o !== exp_word) begin fails++; $display("FAIL trunc_dat got=%h want=%h", upg_dat_o, exp_word); end
      checks++; if (upg_done_o !== (k == 4)) begin fails++; $display("FAIL trunc_done k=%0d got=%b want=%b", k, upg_done_o, (k == 4)); end
    end
    tick(2);
    checks++; if (wen_total - base !== 5) begin fails++; $display("FAIL trunc_wen_count got=%0d want=5", wen_total - base); end
    $display("test_header_trunc: header 05 80 gives writes=%0d", wen_total - base);
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_zero_len();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_header_trunc();
    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule
